// File: rtl/neokeon_theta_pipe.sv
// Neokeon Theta round function with optional key addition, split over one or two
// valid/ready pipeline stages (half 1 + key, then half 2).
module neokeon_theta_pipe #(
    parameter int WORD_W = 32,
    parameter int ROT    = 8,
    parameter int STAGES = 2
) (
    input  logic                  inClk,
    input  logic                  inRst,
    input  logic                  inValid,
    output logic                  outReady,
    input  logic                  inModeKey,
    input  logic [4*WORD_W-1:0]   inDataState,
    input  logic [4*WORD_W-1:0]   inDataKey,
    output logic                  outValid,
    input  logic                  inReady,
    output logic [4*WORD_W-1:0]   outDataState,
    output logic                  outBusy
);

    localparam int DW = 4 * WORD_W;

    function automatic logic [WORD_W-1:0] mix_word(input logic [WORD_W-1:0] t);
        logic [WORD_W-1:0] rr;
        logic [WORD_W-1:0] rl;
        rr = (t >> ROT) | (t << (WORD_W - ROT));
        rl = (t << ROT) | (t >> (WORD_W - ROT));
        return t ^ rr ^ rl;
    endfunction

    function automatic logic [DW-1:0] half2(input logic [DW-1:0] s);
        logic [WORD_W-1:0] a0, a1, a2, a3, u;
        {a0, a1, a2, a3} = s;
        u = mix_word(a1 ^ a3);
        return {a0 ^ u, a1, a2 ^ u, a3};
    endfunction

    // Half 1 plus key addition, word 0 sits in the most significant word.
    logic [WORD_W-1:0] a_w  [4];
    logic [WORD_W-1:0] k_w  [4];
    logic [WORD_W-1:0] h1_w [4];
    logic [WORD_W-1:0] t1;
    logic [DW-1:0]     h1;

    assign t1 = mix_word(a_w[0] ^ a_w[2]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            assign a_w[gi]  = inDataState[DW-1-gi*WORD_W -: WORD_W];
            assign k_w[gi]  = inModeKey ? inDataKey[DW-1-gi*WORD_W -: WORD_W] : '0;
            assign h1_w[gi] = a_w[gi] ^ k_w[gi] ^ (((gi % 2) == 1) ? t1 : '0);
            assign h1[DW-1-gi*WORD_W -: WORD_W] = h1_w[gi];
        end
    endgenerate

    // Output register; its feed is either stage 1 or the input side directly.
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          out_adv;
    logic          feed_valid;
    logic [DW-1:0] feed_data;

    assign out_adv = !out_valid_q || inReady;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (out_adv) begin
            out_valid_d = feed_valid;
            if (feed_valid) begin
                out_data_d = half2(feed_data);
            end
        end
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            logic          s1_valid_q, s1_valid_d;
            logic [DW-1:0] s1_data_q,  s1_data_d;
            logic          accept;

            // Stage 1 frees up whenever the output register can take its contents.
            assign outReady = !inRst && (!s1_valid_q || out_adv);
            assign accept   = inValid && outReady;

            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_data_d  = s1_data_q;
                if (accept) begin
                    s1_valid_d = 1'b1;
                    s1_data_d  = h1;
                end else if (out_adv) begin
                    s1_valid_d = 1'b0;
                end
            end

            always_ff @(posedge inClk) begin
                if (inRst) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                end
            end

            assign feed_valid = s1_valid_q;
            assign feed_data  = s1_data_q;
            assign outBusy    = s1_valid_q | out_valid_q;
        end else begin : g_one
            assign outReady   = !inRst && out_adv;
            assign feed_valid = inValid && outReady;
            assign feed_data  = h1;
            assign outBusy    = out_valid_q;
        end
    endgenerate

    assign outValid     = out_valid_q;
    assign outDataState = out_data_q;

endmodule

// File: doc/neokeon_theta_pipe.md
NEOKEON_THETA_PIPE -- requirements
Module: neokeon_theta_pipe

Interface
REQ-001 Parameter WORD_W, default 32, SHALL set the word width; state and key are each 4 words wide.
REQ-002 Parameter ROT, default 8, SHALL set the rotation distance; legal range 1..WORD_W-1.
REQ-003 Parameter STAGES, default 2, SHALL set the pipeline depth; legal values 1 or 2.
REQ-004 inClk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 inRst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 inValid  input  1  SHALL indicate that inDataState, inDataKey and inModeKey are valid.
REQ-007 outReady  output  1  SHALL indicate that the block accepts input this cycle.
REQ-008 inModeKey  input  1  SHALL select key addition when 1; when 0, the key is treated as all-zero.
REQ-009 inDataState  input  4*WORD_W  SHALL carry state words A0..A3, with A0 in the MSB word.
REQ-010 inDataKey  input  4*WORD_W  SHALL carry key words K0..K3, with K0 in the MSB word.
REQ-011 outValid  output  1  SHALL indicate that outDataState holds a result.
REQ-012 inReady  input  1  SHALL indicate that downstream accepts the result this cycle.
REQ-013 outDataState  output  4*WORD_W  SHALL carry result words A0..A3, with A0 in the MSB word.
REQ-014 outBusy  output  1  SHALL be high while any pipeline stage holds valid data.

Function
REQ-015 Transform, half 1, SHALL be: T = A0^A2; T = T^ROTR(T,ROT)^ROTL(T,ROT); A1^=T; A3^=T; then Ai^=Ki for i=0..3.
REQ-016 Transform, half 2, SHALL be: U = A1^A3; U = U^ROTR(U,ROT)^ROTL(U,ROT); A0^=U; A2^=U.
REQ-017 All XOR and rotate operations SHALL be WORD_W-bit with no width growth; rotations are circular within a word.
REQ-018 STAGES=2: half 1 SHALL complete before the stage-1 register and half 2 before the output register. Only 4*WORD_W bits are held per stage; the key is not carried forward.
REQ-019 STAGES=1: both halves SHALL be combinational into the single output register.
REQ-020 A transfer into the block SHALL occur when inValid && outReady; a transfer out SHALL occur when outValid && inReady.
REQ-021 Each stage k SHALL load when its input is valid and (stage k is empty or stage k advances this cycle); outReady = stage-1 empty or stage 1 advances.
REQ-022 Latency SHALL be exactly STAGES cycles from accept to outValid, given no stall; throughput SHALL be 1 transfer per cycle under continuous inReady.
REQ-023 While outValid && !inReady, outDataState SHALL hold stable, and no data SHALL be dropped or duplicated at any stage.
REQ-024 Simultaneous accept and drain on a full pipeline SHALL proceed without a bubble.
REQ-025 outBusy SHALL equal the OR of all stage valid flags.
REQ-026 inModeKey SHALL be sampled with its transfer only; changing it mid-flight SHALL NOT affect in-flight data.

Reset
REQ-027 While inRst=1 at a clock edge, all valid flags SHALL clear and all data registers SHALL load zero. outValid=0, outBusy=0 and outDataState=0 in the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight data; no output SHALL appear for it after reset.
REQ-029 During reset, outReady SHALL be 0, and input SHALL NOT be accepted.

Verification (WORD_W=32, ROT=8)
REQ-030 State 0x00000001_00000000_00000000_00000000, key 0, mode 1 -> outDataState 0x00000001_01000101_00000000_01000101 after STAGES cycles.
REQ-031 State 0, key 0x00000000_00000000_00000000_00000001, mode 1 -> 0x01000101_00000000_01000101_00000001; same input with mode 0 -> all-zero.
REQ-032 Random state, mode 0, result fed back through the block -> original state returned (involution check), for STAGES=1 and STAGES=2.
REQ-033 Continuous inValid with random inReady stalls for 1000 transactions -> in-order results matching the reference model, none dropped or duplicated, outDataState stable during stalls.
REQ-034 Assert inRst for 1 cycle with the pipeline full -> next cycle outValid=0, outBusy=0, outDataState=0; no pre-reset result emitted afterwards.
